// File: rtl/poly_load_ctrl_multi.sv
// poly_load_ctrl_multi: streams 1..NUM_POLY polynomials from a valid/ready source into consecutive BRAM slots
module poly_load_ctrl_multi #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 6,
  parameter int WORDS_4X = 64,
  parameter int WORDS_PK = 52,
  parameter int NUM_POLY = 3,
  parameter int PIDX_W   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     coeff4x,
  input  logic [PIDX_W-1:0]        num_poly,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic                     bram_we,
  output logic [PIDX_W+ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0]        bram_wdata,
  output logic                     poly_done,
  output logic                     busy,
  output logic                     done
);
  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;
  localparam logic [ADDR_W-1:0] LAST_4X = ADDR_W'(WORDS_4X - 1);
  localparam logic [ADDR_W-1:0] LAST_PK = ADDR_W'(WORDS_PK - 1);
  localparam logic [PIDX_W:0]   NP_MAX  = (PIDX_W+1)'(NUM_POLY);
  state_t             state;
  logic               mode;
  logic [PIDX_W-1:0]  last_poly;
  logic [ADDR_W-1:0]  word_cnt;
  logic [PIDX_W-1:0]  poly_cnt;
  logic [PIDX_W:0]    np_eff;
  logic               word_last;
  // count is held one extra bit wide so NUM_POLY == 2^PIDX_W clamps correctly
  assign np_eff = (num_poly == '0) ? (PIDX_W+1)'(1) :
                  ({1'b0, num_poly} > NP_MAX) ? NP_MAX : {1'b0, num_poly};
  assign word_last = word_cnt == (mode ? LAST_4X : LAST_PK);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      mode       <= 1'b0;
      last_poly  <= '0;
      word_cnt   <= '0;
      poly_cnt   <= '0;
      in_ready   <= 1'b0;
      bram_we    <= 1'b0;
      bram_addr  <= '0;
      bram_wdata <= '0;
      poly_done  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      bram_we   <= 1'b0;
      poly_done <= 1'b0;
      done      <= 1'b0;
      case (state)
        IDLE: if (start) begin
          mode      <= coeff4x;
          last_poly <= PIDX_W'(np_eff - (PIDX_W+1)'(1));
          word_cnt  <= '0;
          poly_cnt  <= '0;
          in_ready  <= 1'b1;
          busy      <= 1'b1;
          state     <= LOAD;
        end
        LOAD: if (in_valid) begin
          bram_we    <= 1'b1;
          bram_addr  <= {poly_cnt, word_cnt};
          bram_wdata <= in_data;
          poly_done  <= word_last;
          word_cnt   <= word_last ? '0 : word_cnt + 1'b1;
          if (word_last) begin
            poly_cnt <= poly_cnt + 1'b1;
            if (poly_cnt == last_poly) begin
              in_ready <= 1'b0;
              state    <= FLUSH;
            end
          end
        end
        FLUSH: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_poly_load_ctrl_multi.sv
// tb_poly_load_ctrl_multi: directed runs checked every cycle against a word-count model of the loader
module tb_poly_load_ctrl_multi;
  localparam int MAXP = 3;
  logic        clk = 0, rst = 1, start = 0, coeff4x = 0, in_valid = 0;
  logic [1:0]  num_poly = 0;
  logic [63:0] in_data = 0;
  logic        in_ready, bram_we, poly_done, busy, done;
  logic [7:0]  bram_addr;
  logic [63:0] bram_wdata;
  logic        u2_in_ready, u2_bram_we, u2_poly_done, u2_busy, u2_done;
  logic [7:0]  u2_bram_addr;
  logic [63:0] u2_bram_wdata;
  int checks = 0, passed = 0;
  bit wr [256];

  poly_load_ctrl_multi dut (
    .clk(clk), .rst(rst), .start(start), .coeff4x(coeff4x), .num_poly(num_poly),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .bram_we(bram_we),
    .bram_addr(bram_addr), .bram_wdata(bram_wdata), .poly_done(poly_done),
    .busy(busy), .done(done));

  poly_load_ctrl_multi #(.NUM_POLY(2)) u2 (
    .clk(clk), .rst(rst), .start(start), .coeff4x(coeff4x), .num_poly(num_poly),
    .in_data(in_data), .in_valid(in_valid), .in_ready(u2_in_ready), .bram_we(u2_bram_we),
    .bram_addr(u2_bram_addr), .bram_wdata(u2_bram_wdata), .poly_done(u2_poly_done),
    .busy(u2_busy), .done(u2_done));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Model: a run is m_total accepted words; the k-th lands at slot k/wpp, word k%wpp.
  logic        e_we, e_pd, e_busy, e_done, e_ready;
  logic [7:0]  e_addr;
  logic [63:0] e_wdata;
  bit          m_load;
  int          m_k, m_total, m_wpp, m_post;

  function automatic int eff_np(input logic [1:0] n);
    return n == 0 ? 1 : (int'(n) > MAXP ? MAXP : int'(n));
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      e_we <= 0; e_pd <= 0; e_busy <= 0; e_done <= 0; e_ready <= 0;
      e_addr <= 0; e_wdata <= 0; m_load <= 0; m_k <= 0; m_total <= 0; m_wpp <= 64; m_post <= 0;
    end else begin
      e_we <= 0;
      e_pd <= 0;
      e_done <= (m_post == 2);
      if (m_post == 2) begin m_post <= 1; e_busy <= 0; end
      if (m_post == 1) m_post <= 0;
      if (m_load && in_valid) begin
        e_we <= 1;
        e_addr <= 8'((m_k / m_wpp) * 64 + m_k % m_wpp);
        e_wdata <= in_data;
        e_pd <= (m_k % m_wpp) == m_wpp - 1;
        m_k <= m_k + 1;
        if (m_k + 1 == m_total) begin m_load <= 0; e_ready <= 0; m_post <= 2; end
      end
      if (!m_load && m_post == 0 && start) begin
        m_wpp <= coeff4x ? 64 : 52;
        m_total <= (coeff4x ? 64 : 52) * eff_np(num_poly);
        m_k <= 0; m_load <= 1; e_ready <= 1; e_busy <= 1;
      end
    end
  end

  always @(negedge clk) begin
    chk("in_ready", in_ready, e_ready);
    chk("bram_we", bram_we, e_we);
    chk("bram_addr", bram_addr, e_addr);
    chk("bram_wdata", bram_wdata, e_wdata);
    chk("poly_done", poly_done, e_pd);
    chk("busy", busy, e_busy);
    chk("done", done, e_done);
  end

  // Cycle 0 is the cycle start is high; in_data carries the index of the next word to accept.
  task automatic run(input bit m, input logic [1:0] np, input bit tog, input bit poke, input int abort_at,
                     output int dcyc, output int nw, output int nw2, output int pd_first, output int pd_last);
    int acc = 0, cyc = 0;
    bit x;
    dcyc = -1; nw = 0; nw2 = 0; pd_first = -1; pd_last = -1;
    foreach (wr[i]) wr[i] = 0;
    start = 1; coeff4x = m; num_poly = np; in_valid = 1; in_data = 64'hC0DE_0000_0000_0000;
    for (int i = 0; i < 400; i++) begin
      x = in_ready && in_valid;
      @(posedge clk); #1;
      cyc++;
      start = poke && (cyc == 10);
      if (x) acc++;
      if (bram_we) begin nw++; wr[bram_addr] = 1; end
      if (u2_bram_we) nw2++;
      if (poly_done) begin if (pd_first < 0) pd_first = cyc; pd_last = cyc; end
      if (done) begin
        dcyc = cyc;
        chk("busy_at_done", busy, 0);
        start = poke;
        break;
      end
      if (abort_at > 0 && acc == abort_at) return;
      in_valid = tog ? (cyc % 2 == 1) : 1'b1;
      in_data = 64'hC0DE_0000_0000_0000 | 64'(acc);
    end
  endtask

  task automatic idle_check(output int nd, output int nwe);
    nd = 0; nwe = 0;
    repeat (6) begin
      @(posedge clk); #1;
      start = 0;
      if (done) nd++;
      if (bram_we) nwe++;
    end
  endtask

  initial begin
    int dc, nw, nw2, pf, pl, nd, nwe, bad;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_we", bram_we, 0);
    chk("rst_addr", bram_addr, 0);
    @(posedge clk); #1;

    run(1, 3, 0, 0, 0, dc, nw, nw2, pf, pl);
    chk("t1_done_cyc", dc, 194);
    chk("t1_writes", nw, 192);
    chk("t1_pd_first", pf, 65);
    chk("t1_pd_last", pl, 193);
    chk("t1_last_addr", wr[8'hBF], 1);
    idle_check(nd, nwe);
    chk("t1_extra_done", nd, 0);

    run(0, 2, 0, 0, 0, dc, nw, nw2, pf, pl);
    chk("t2_done_cyc", dc, 106);
    chk("t2_writes", nw, 104);
    bad = 0;
    for (int a = 8'h34; a <= 8'h3F; a++) bad += int'(wr[a]);
    chk("t2_gap_unwritten", bad, 0);
    chk("t2_last_addr", wr[8'h73], 1);
    idle_check(nd, nwe);

    run(1, 1, 1, 0, 0, dc, nw, nw2, pf, pl);
    chk("t3_writes", nw, 64);
    chk("t3_done_cyc", dc, 129);
    idle_check(nd, nwe);

    run(1, 0, 0, 0, 0, dc, nw, nw2, pf, pl);
    chk("t4_np0_writes", nw, 64);
    chk("t4_np0_done_cyc", dc, 66);
    idle_check(nd, nwe);

    run(0, 3, 0, 0, 0, dc, nw, nw2, pf, pl);
    chk("t4_np3_writes", nw, 156);
    chk("t4_np3_done_cyc", dc, 158);
    chk("t4_clamp2_writes", nw2, 104);
    idle_check(nd, nwe);

    run(1, 2, 0, 1, 0, dc, nw, nw2, pf, pl);
    chk("t5_done_cyc", dc, 130);
    chk("t5_writes", nw, 128);
    idle_check(nd, nwe);
    chk("t5_extra_done", nd, 0);
    chk("t5_extra_we", nwe, 0);

    run(1, 3, 0, 0, 94, dc, nw, nw2, pf, pl);
    chk("t6_pre_abort_busy", busy, 1);
    #2 rst = 1;
    #1;
    chk("t6_rst_we", bram_we, 0);
    chk("t6_rst_addr", bram_addr, 0);
    chk("t6_rst_wdata", bram_wdata, 0);
    chk("t6_rst_pd", poly_done, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_ready", in_ready, 0);
    chk("t6_rst_done", done, 0);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    idle_check(nd, nwe);
    chk("t6_no_we_after_rst", nwe, 0);
    run(1, 1, 0, 0, 0, dc, nw, nw2, pf, pl);
    chk("t6_reload_done_cyc", dc, 66);
    chk("t6_reload_addr0", wr[0], 1);
    idle_check(nd, nwe);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/poly_load_ctrl_multi.md
# poly_load_ctrl_multi

Parametrised polynomial-load controller that streams a run of 1 to NUM_POLY polynomials from the input data port into the polynomial BRAM. The source sets the pace through a valid/ready handshake. Each polynomial is 64 words in 4×uint16 mode or 52 words in packed 13-bit mode, and consecutive polynomials land in consecutive address slots. This block sits between the host/AXI input path and the polynomial BRAM. It replaces the fixed single-polynomial, free-running loader with a restartable controller that tolerates stalls.

## Interface
- DATA_W, 64, BRAM word width
- ADDR_W, 6, word-address width inside one polynomial slot
- WORDS_4X, 64, words per polynomial when coeff4x=1 (≤ 2^ADDR_W)
- WORDS_PK, 52, words per polynomial when coeff4x=0 (≤ 2^ADDR_W)
- NUM_POLY, 3, maximum polynomials per run
- PIDX_W, 2, polynomial-index width (2^PIDX_W ≥ NUM_POLY)

- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, asynchronous and active-high
- start  in  1  one-cycle run request, honoured only in IDLE
- coeff4x  in  1  mode, sampled at start: 1 = 4 coeffs/word (WORDS_4X), 0 = packed (WORDS_PK)
- num_poly  in  PIDX_W  polynomial count, sampled at start; 0 is treated as 1, values above NUM_POLY are clamped to NUM_POLY
- in_data  in  DATA_W  input word
- in_valid  in  1  in_data is valid
- in_ready  out  1  controller accepts a word this cycle
- bram_we  out  1  BRAM write enable (registered)
- bram_addr  out  PIDX_W+ADDR_W  {poly_idx, word_idx} (registered)
- bram_wdata  out  DATA_W  registered copy of the accepted in_data
- poly_done  out  1  one-cycle pulse, coincident with the write of each polynomial's last word
- busy  out  1  high in LOAD and FLUSH
- done  out  1  one-cycle pulse at end of run

## Operation
- States: IDLE, LOAD, FLUSH, DONE.
- IDLE: in_ready=0, busy=0. On start=1: latch the mode and the effective count, clear word_cnt and poly_cnt, go to LOAD.
- LOAD: in_ready=1. A transfer happens on a cycle with in_valid & in_ready. On each transfer:
  - bram_we <= 1
  - bram_addr <= {poly_cnt, word_cnt}
  - bram_wdata <= in_data
  - word_cnt increments
- Polynomial boundary: when the transfer has word_cnt = last (WORDS_4X-1 or WORDS_PK-1 per the latched mode), word_cnt wraps to 0 and poly_cnt increments. poly_done is registered with that write.
- If that transfer was for poly_cnt = count-1, next state is FLUSH; otherwise stay in LOAD with no gap cycle.
- in_valid=0 in LOAD stalls the run: counters hold and bram_we=0 the next cycle. Stalls may be of any length.
- FLUSH: in_ready=0. The final write is presented on bram_* this cycle. Next state is DONE.
- DONE: done=1, busy=0, in_ready=0. Next state is IDLE.
- start is ignored outside IDLE, including in DONE. start asserted on the same cycle done is high is lost.
- bram_we is 0 on every cycle without a preceding transfer. bram_addr and bram_wdata hold their last values when bram_we=0.
- Counter widths: word_cnt is ADDR_W bits, poly_cnt is PIDX_W bits. Unused address slots (words ≥ WORDS_PK in packed mode) are never written.

## Timing
- Reset (asynchronous, any state, mid-run included): state=IDLE; word_cnt, poly_cnt, bram_we, bram_addr, bram_wdata, poly_done, busy, done, in_ready all 0. No write occurs after reset assertion. A new start is required afterwards.
- start sampled at cycle 0. in_ready=1 and busy=1 from cycle 1.
- Write latency is 1 cycle: a transfer at cycle t appears on bram_* at t+1.
- Final transfer at cycle t: FLUSH at t+1 (final write, poly_done=1), done=1 at t+2, IDLE at t+3.
- With in_valid held at 1, a run of N words total gives done at cycle N+2.

## Test plan
- coeff4x=1, num_poly=3, in_valid constant 1, in_data=word index, start at cycle 0 -> 192 writes at cycles 2..193 with addresses 0x00..0x3F, 0x40..0x7F, 0x80..0xBF; poly_done at cycles 65, 129, 193; done=1 only at cycle 194; busy low from cycle 194.
- coeff4x=0, num_poly=2 -> 104 writes at addresses 0x00..0x33 then 0x40..0x73; addresses 0x34..0x3F are never written; done at cycle 106.
- in_valid toggled 1,0 each cycle with coeff4x=1, num_poly=1 -> exactly 64 writes with bram_we alternating; addresses and data match the accepted words in order; no duplicates or skips.
- num_poly=0, then num_poly=3 with NUM_POLY=2 -> one polynomial loaded in the first case, two in the second.
- start pulsed during LOAD and during DONE -> ignored; no counter reset; exactly one done per honoured start.
- rst asserted mid-run (after 30 words of polynomial 1) -> all outputs 0 asynchronously; no further bram_we; a following start reloads from address 0x00.
